cpu_run_ctrl: RTL and testbench
===============================

CPU_RUN_CTRL -- requirements
Module: cpu_run_ctrl

Interface
REQ-001 SHALL have parameter DB_CYCLES, default 1000000, meaning the number of consecutive stable cycles before a step_btn level change is accepted (minimum 2).
REQ-002 SHALL have port cpu_clk, input, 1, the single clock; all flops use its rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port step_btn, input, 1, raw asynchronous single-step push button.
REQ-005 SHALL have port run_sw, input, 1, raw asynchronous run switch (1 = run).
REQ-006 SHALL have port bp_en, input, 1, breakpoint enable.
REQ-007 SHALL have port bp_addr, input, 32, breakpoint PC.
REQ-008 SHALL have port watch_pc, input, 32, current CPU PC.
REQ-009 SHALL have port cpu_en, output, 1, CPU clock enable; the CPU advances one cycle per high cycle.
REQ-010 SHALL have port halted, output, 1, high in IDLE or BREAK.
REQ-011 SHALL have port state, output, 2, encoding IDLE=0, STEP=1, RUN=2, BREAK=3.
REQ-012 SHALL have port cycle_cnt, output, 32, count of enabled CPU cycles.

Function
REQ-013 step_btn and run_sw SHALL each pass through a 2-flop synchronizer; s_step and s_run denote the synchronizer outputs.
REQ-014 Debounce: the counter SHALL increment on each edge where s_step differs from the filtered level; when s_step equals the filtered level, the counter SHALL clear.
REQ-015 When the counter equals DB_CYCLES-1 and s_step still differs at an edge, the filtered level SHALL take s_step and the counter SHALL clear.
REQ-016 step_req SHALL be the combinational rising edge of the filtered level (filtered AND NOT its registered copy), high for exactly 1 cycle.
REQ-017 run_rise and run_fall SHALL be the combinational edges of s_run against its registered copy.
REQ-018 bp_hit SHALL equal bp_en AND (watch_pc == bp_addr), using a full 32-bit compare.
REQ-019 IDLE: run_rise SHALL go to RUN; otherwise step_req SHALL go to STEP; a simultaneous run_rise and step_req SHALL go to RUN and the step SHALL be discarded.
REQ-020 STEP SHALL last exactly 1 cycle, then go to IDLE unconditionally; step_req, run_sw and bp_hit SHALL be ignored in STEP.
REQ-021 RUN: run_fall SHALL go to IDLE; otherwise bp_hit SHALL go to BREAK; otherwise the state SHALL remain RUN.
REQ-022 BREAK: run_fall SHALL go to IDLE; otherwise step_req SHALL go to STEP; the state SHALL remain BREAK even while run_sw stays high.
REQ-023 cpu_en SHALL be (state==STEP) OR (state==RUN AND NOT bp_hit), combinational, so the instruction at bp_addr is not entered.
REQ-024 Resuming after a break SHALL require run_sw low then high; if watch_pc still equals bp_addr, RUN SHALL re-break immediately with no cpu_en cycle.
REQ-025 Step latency: cpu_en SHALL assert for 1 cycle exactly DB_CYCLES+3 rising edges after the first edge that samples step_btn high, provided the button is held stable.
REQ-026 Releasing the button SHALL NOT produce a step; a new step SHALL require a debounced release followed by a debounced press.
REQ-027 halted SHALL be high in IDLE and BREAK, and low in STEP and RUN.

Reset
REQ-028 rst low SHALL immediately force state=IDLE, cpu_en=0, halted=1, cycle_cnt=0, synchronizer and edge registers to 0, filtered level 0, and debounce counter 0.
REQ-029 Reset asserted during any state, including mid-debounce, SHALL abort that state without emitting a cpu_en pulse.

Configuration
REQ-030 With macro CPU_RUN_CTRL_CYCLE_COUNT_EN defined, cycle_cnt SHALL increment by 1 on every edge where cpu_en=1 and wrap from 0xFFFFFFFF to 0.
REQ-031 With the macro undefined, cycle_cnt SHALL be constant 0 and no counter flops SHALL be built.

Verification (DB_CYCLES=4, macro defined)
REQ-032 Hold step_btn high from edge 10 -> cpu_en high only in the cycle after edge 17, state 0->1->0, cycle_cnt=1.
REQ-033 Toggle step_btn every 2 cycles for 20 cycles, then hold low -> no cpu_en pulse, debounce counter never reaches 3.
REQ-034 run_sw=1, bp_en=1, bp_addr=0x10, watch_pc stepping 0x0,0x4,0x8,0xC,0x10 -> state=3 when PC=0x10, cpu_en=0 in that cycle, cycle_cnt=4.
REQ-035 In BREAK, press step -> exactly one cpu_en cycle, state then 0; toggle run_sw 0->1 with PC=0x14 -> RUN resumes.
REQ-036 Preload cycle_cnt to 0xFFFFFFFF (force) while in RUN -> next enabled edge gives 0; assert rst mid-RUN -> cpu_en=0 and state=0 without waiting for a clock edge.

Source files
------------

// File: rtl/cpu_run_ctrl.sv
`timescale 1ns/1ps
// cpu_run_ctrl: run / single-step / breakpoint controller that gates the CPU through cpu_en.
// Latency: held press -> cpu_en on the (DB_CYCLES+3)th edge counting the first sampling edge; run edge -> RUN 3 edges later.
// Backpressure: none; the CPU is throttled only by cpu_en. Define CPU_RUN_CTRL_CYCLE_COUNT_EN to build the cycle counter.
module cpu_run_ctrl #(
    parameter int unsigned DB_CYCLES = 1000000
) (
    input  logic        cpu_clk,
    input  logic        rst,
    input  logic        step_btn,
    input  logic        run_sw,
    input  logic        bp_en,
    input  logic [31:0] bp_addr,
    input  logic [31:0] watch_pc,
    output logic        cpu_en,
    output logic        halted,
    output logic [1:0]  state,
    output logic [31:0] cycle_cnt
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] STEP  = 2'd1;
    localparam logic [1:0] RUN   = 2'd2;
    localparam logic [1:0] BREAK = 2'd3;

    localparam int unsigned CW = $clog2(DB_CYCLES);
    localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);

    logic          step_meta;
    logic          s_step;
    logic          run_meta;
    logic          s_run;
    logic          run_q;
    logic          filt;
    logic          filt_q;
    logic [CW-1:0] db_cnt;
    logic [1:0]    state_nxt;

    logic step_req;
    logic run_rise;
    logic run_fall;
    logic bp_hit;

    always_ff @(posedge cpu_clk or negedge rst) begin
        if (!rst) begin
            step_meta <= 1'b0;
            s_step    <= 1'b0;
            run_meta  <= 1'b0;
            s_run     <= 1'b0;
            run_q     <= 1'b0;
            filt      <= 1'b0;
            filt_q    <= 1'b0;
            db_cnt    <= '0;
        end else begin
            step_meta <= step_btn;
            s_step    <= step_meta;
            run_meta  <= run_sw;
            s_run     <= run_meta;
            run_q     <= s_run;
            filt_q    <= filt;
            // Any cycle where the synchronized button agrees with the filtered level restarts the count.
            if (s_step == filt) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                filt   <= s_step;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    assign step_req = filt & ~filt_q;
    assign run_rise = s_run & ~run_q;
    assign run_fall = ~s_run & run_q;
    assign bp_hit   = bp_en & (watch_pc == bp_addr);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (run_rise)      state_nxt = RUN;
                else if (step_req) state_nxt = STEP;
            end
            STEP: state_nxt = IDLE;
            RUN: begin
                if (run_fall)      state_nxt = IDLE;
                else if (bp_hit)   state_nxt = BREAK;
            end
            BREAK: begin
                if (run_fall)      state_nxt = IDLE;
                else if (step_req) state_nxt = STEP;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge cpu_clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Masking on bp_hit keeps the CPU from entering the instruction at bp_addr.
    assign cpu_en = (state == STEP) | ((state == RUN) & ~bp_hit);
    assign halted = (state == IDLE) | (state == BREAK);

`ifdef CPU_RUN_CTRL_CYCLE_COUNT_EN
    always_ff @(posedge cpu_clk or negedge rst) begin
        if (!rst)        cycle_cnt <= '0;
        else if (cpu_en) cycle_cnt <= cycle_cnt + 32'd1;
    end
`else
    assign cycle_cnt = '0;
`endif

endmodule

// File: tb/tb_cpu_run_ctrl.sv
`timescale 1ns/1ps
// Bench for cpu_run_ctrl with DB_CYCLES=4: directed scenarios plus randomized traffic against a history-based model.
module tb_cpu_run_ctrl;
    localparam int DB = 4;
`ifdef CPU_RUN_CTRL_CYCLE_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        cpu_clk = 1'b0;
    logic        rst = 1'b0;
    logic        step_btn = 1'b0;
    logic        run_sw = 1'b0;
    logic        bp_en = 1'b0;
    logic [31:0] bp_addr = 32'd0;
    logic [31:0] watch_pc = 32'd0;
    logic        cpu_en;
    logic        halted;
    logic [1:0]  state;
    logic [31:0] cycle_cnt;

    int total = 0;
    int bad = 0;

    cpu_run_ctrl #(.DB_CYCLES(DB)) dut (
        .cpu_clk  (cpu_clk),
        .rst      (rst),
        .step_btn (step_btn),
        .run_sw   (run_sw),
        .bp_en    (bp_en),
        .bp_addr  (bp_addr),
        .watch_pc (watch_pc),
        .cpu_en   (cpu_en),
        .halted   (halted),
        .state    (state),
        .cycle_cnt(cycle_cnt)
    );

    always #5 cpu_clk = ~cpu_clk;

    // Reference model: input histories (index 0 = value sampled at the latest edge).
    bit          btn_h[$];
    bit          run_h[$];
    logic [1:0]  m_state;
    bit          m_filt;
    bit          m_filt_prev;
    bit          m_en_last;
    logic [31:0] m_cnt;

    function automatic bit m_bp_hit();
        return bp_en && (watch_pc == bp_addr);
    endfunction

    task automatic model_reset();
        btn_h.delete();
        run_h.delete();
        for (int i = 0; i < DB + 3; i++) begin
            btn_h.push_back(1'b0);
            run_h.push_back(1'b0);
        end
        m_state = 2'd0; m_filt = 1'b0; m_filt_prev = 1'b0; m_en_last = 1'b0; m_cnt = 32'd0;
    endtask

    task automatic model_edge();
        bit step_req, rise, fall, hit, en, all_other;
        logic [1:0] nxt;
        if (!rst) begin
            model_reset();
            return;
        end
        btn_h.push_front(step_btn);
        run_h.push_front(run_sw);
        void'(btn_h.pop_back());
        void'(run_h.pop_back());
        step_req = m_filt && !m_filt_prev;
        rise = run_h[2] && !run_h[3];
        fall = !run_h[2] && run_h[3];
        hit = m_bp_hit();
        en = (m_state == 2'd1) || (m_state == 2'd2 && !hit);
        m_en_last = en;
        if (en) m_cnt = m_cnt + 32'd1;
        // The filtered level flips once the last DB synchronized samples all disagree with it.
        all_other = 1'b1;
        for (int i = 2; i < DB + 2; i++) if (btn_h[i] == m_filt) all_other = 1'b0;
        m_filt_prev = m_filt;
        if (all_other) m_filt = !m_filt;
        nxt = m_state;
        case (m_state)
            2'd0: if (rise) nxt = 2'd2; else if (step_req) nxt = 2'd1;
            2'd1: nxt = 2'd0;
            2'd2: if (fall) nxt = 2'd0; else if (hit) nxt = 2'd3;
            default: if (fall) nxt = 2'd0; else if (step_req) nxt = 2'd1;
        endcase
        m_state = nxt;
    endtask

    task automatic tick();
        @(posedge cpu_clk);
        model_edge();
        #2;
    endtask

    task automatic go_run();
        run_sw = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        run_sw = 1'b1;
        for (int i = 0; i < 3; i++) tick();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #3;
        total++;
        if (state !== 2'd0 || cpu_en !== 1'b0 || halted !== 1'b1 || cycle_cnt !== 32'd0) begin
            bad++;
            $display("FAIL reset_values: state=%0d cpu_en=%b halted=%b cycle_cnt=%0d, want 0 0 1 0",
                     state, cpu_en, halted, cycle_cnt);
        end
        tick(); tick();
        rst = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        total++;
        if (state !== 2'd0 || halted !== 1'b1) begin
            bad++;
            $display("FAIL idle_after_reset: state=%0d halted=%b, want 0 1", state, halted);
        end
    endtask

    task automatic test_step_latency();
        logic [1:0] exp_s;
        step_btn = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            exp_s = (i == 7) ? 2'd1 : 2'd0;
            total++;
            if (cpu_en !== (i == 7)) begin
                bad++;
                $display("FAIL step_latency_en edge %0d: cpu_en=%b want %b", i, cpu_en, (i == 7));
            end
            total++;
            if (state !== exp_s) begin
                bad++;
                $display("FAIL step_latency_state edge %0d: state=%0d want %0d", i, state, exp_s);
            end
        end
        total++;
        if (cycle_cnt !== (CNT_EN ? 32'd1 : 32'd0)) begin
            bad++;
            $display("FAIL step_count: cycle_cnt=%0d want %0d", cycle_cnt, CNT_EN ? 1 : 0);
        end
        step_btn = 1'b0;
        for (int i = 0; i < 14; i++) begin
            tick();
            total++;
            if (cpu_en !== 1'b0 || state !== 2'd0) begin
                bad++;
                $display("FAIL release_no_step cycle %0d: cpu_en=%b state=%0d want 0 0", i, cpu_en, state);
            end
        end
    endtask

    task automatic test_bounce();
        int max_cnt;
        int pulses;
        max_cnt = 0;
        pulses = 0;
        for (int i = 0; i < 35; i++) begin
            step_btn = (i < 20) ? (((i >> 1) & 1) == 0) : 1'b0;
            tick();
            if (cpu_en === 1'b1 || state !== 2'd0) pulses++;
            if (int'(dut.db_cnt) > max_cnt) max_cnt = int'(dut.db_cnt);
        end
        total++;
        if (pulses != 0) begin
            bad++;
            $display("FAIL bounce_pulses: got %0d non-idle/enabled cycles, want 0", pulses);
        end
        total++;
        if (max_cnt >= DB - 1) begin
            bad++;
            $display("FAIL bounce_counter: max debounce count %0d, want below %0d", max_cnt, DB - 1);
        end
        total++;
        if (cycle_cnt !== (CNT_EN ? 32'd1 : 32'd0)) begin
            bad++;
            $display("FAIL bounce_count: cycle_cnt=%0d want %0d", cycle_cnt, CNT_EN ? 1 : 0);
        end
    endtask

    task automatic test_reset_mid_debounce();
        step_btn = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b0;
        step_btn = 1'b0;
        #1;
        total++;
        if (cpu_en !== 1'b0 || state !== 2'd0 || cycle_cnt !== 32'd0) begin
            bad++;
            $display("FAIL mid_debounce_reset: cpu_en=%b state=%0d cycle_cnt=%0d want 0 0 0", cpu_en, state, cycle_cnt);
        end
        tick(); tick();
        rst = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            total++;
            if (cpu_en !== 1'b0) begin
                bad++;
                $display("FAIL mid_debounce_no_step cycle %0d: cpu_en=%b want 0", i, cpu_en);
            end
        end
    endtask

    task automatic test_breakpoint();
        bp_en = 1'b1; bp_addr = 32'h10; watch_pc = 32'h0; run_sw = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            total++;
            if (state !== ((i == 3) ? 2'd2 : 2'd0)) begin
                bad++;
                $display("FAIL run_entry edge %0d: state=%0d want %0d", i, state, (i == 3) ? 2 : 0);
            end
        end
        for (int k = 0; k < 4; k++) begin
            total++;
            if (cpu_en !== 1'b1 || state !== 2'd2) begin
                bad++;
                $display("FAIL run_pc_%0h: cpu_en=%b state=%0d want 1 2", watch_pc, cpu_en, state);
            end
            tick();
            watch_pc = watch_pc + 32'd4;
            #1;
        end
        total++;
        if (cpu_en !== 1'b0 || halted !== 1'b0) begin
            bad++;
            $display("FAIL bp_mask: cpu_en=%b halted=%b want 0 0", cpu_en, halted);
        end
        tick();
        total++;
        if (state !== 2'd3 || halted !== 1'b1 || cpu_en !== 1'b0) begin
            bad++;
            $display("FAIL bp_break: state=%0d halted=%b cpu_en=%b want 3 1 0", state, halted, cpu_en);
        end
        total++;
        if (cycle_cnt !== (CNT_EN ? 32'd4 : 32'd0)) begin
            bad++;
            $display("FAIL bp_count: cycle_cnt=%0d want %0d", cycle_cnt, CNT_EN ? 4 : 0);
        end
        for (int i = 0; i < 5; i++) tick();
        total++;
        if (state !== 2'd3) begin
            bad++;
            $display("FAIL break_hold: state=%0d want 3", state);
        end
    endtask

    task automatic test_break_step();
        logic [1:0] exp_s;
        step_btn = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (i == 8) watch_pc = 32'h14;
            #1;
            exp_s = (i < 7) ? 2'd3 : ((i == 7) ? 2'd1 : 2'd0);
            total++;
            if (cpu_en !== (i == 7) || state !== exp_s) begin
                bad++;
                $display("FAIL break_step edge %0d: cpu_en=%b state=%0d want %b %0d", i, cpu_en, state, (i == 7), exp_s);
            end
        end
        total++;
        if (cycle_cnt !== (CNT_EN ? 32'd5 : 32'd0)) begin
            bad++;
            $display("FAIL break_step_count: cycle_cnt=%0d want %0d", cycle_cnt, CNT_EN ? 5 : 0);
        end
        step_btn = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        total++;
        if (state !== 2'd0) begin
            bad++;
            $display("FAIL idle_run_level: state=%0d want 0 (run_sw high without new edge)", state);
        end
        go_run();
        total++;
        if (state !== 2'd2 || cpu_en !== 1'b1) begin
            bad++;
            $display("FAIL resume: state=%0d cpu_en=%b want 2 1", state, cpu_en);
        end
        // Re-break: PC back on the breakpoint, resume must stop with no enabled cycle.
        watch_pc = 32'h10;
        #1;
        tick();
        go_run();
        total++;
        if (state !== 2'd2 || cpu_en !== 1'b0) begin
            bad++;
            $display("FAIL rebreak_run: state=%0d cpu_en=%b want 2 0", state, cpu_en);
        end
        tick();
        total++;
        if (state !== 2'd3) begin
            bad++;
            $display("FAIL rebreak: state=%0d want 3", state);
        end
    endtask

    task automatic test_wrap_and_async_reset();
        watch_pc = 32'h14;
        go_run();
`ifdef CPU_RUN_CTRL_CYCLE_COUNT_EN
        force dut.cycle_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.cycle_cnt;
        tick();
        total++;
        if (cycle_cnt !== 32'd0) begin
            bad++;
            $display("FAIL wrap: cycle_cnt=%h want 00000000", cycle_cnt);
        end
        tick();
        total++;
        if (cycle_cnt !== 32'd1) begin
            bad++;
            $display("FAIL wrap_next: cycle_cnt=%h want 00000001", cycle_cnt);
        end
`endif
        total++;
        if (state !== 2'd2 || cpu_en !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset_run: state=%0d cpu_en=%b want 2 1", state, cpu_en);
        end
        #2;
        rst = 1'b0;
        #1;
        total++;
        if (cpu_en !== 1'b0 || state !== 2'd0 || halted !== 1'b1 || cycle_cnt !== 32'd0) begin
            bad++;
            $display("FAIL async_reset: cpu_en=%b state=%0d halted=%b cycle_cnt=%0d want 0 0 1 0",
                     cpu_en, state, halted, cycle_cnt);
        end
        tick(); tick();
        rst = 1'b1;
    endtask

    task automatic test_random();
        logic [31:0] bp_tab [4];
        int btn_hold, run_hold, bp_hold;
        bit exp_en, exp_halt;
        logic [31:0] exp_cnt;
        int errs;
        bp_tab[0] = 32'h08; bp_tab[1] = 32'h10; bp_tab[2] = 32'h14; bp_tab[3] = 32'h1C;
        btn_hold = 0; run_hold = 0; bp_hold = 0; errs = 0;
        step_btn = 1'b0; run_sw = 1'b0; watch_pc = 32'h0;
        rst = 1'b0;
        tick(); tick();
        rst = 1'b1;
        for (int c = 0; c < 1500; c++) begin
            tick();
            if (m_en_last) watch_pc = (watch_pc + 32'd4) & 32'h1F;
            if (btn_hold == 0) begin
                step_btn = 1'($urandom_range(0, 1));
                btn_hold = int'($urandom_range(1, 9));
            end else btn_hold--;
            if (run_hold == 0) begin
                run_sw = 1'($urandom_range(0, 1));
                run_hold = int'($urandom_range(5, 80));
            end else run_hold--;
            if (bp_hold == 0) begin
                bp_en = 1'($urandom_range(0, 1));
                bp_addr = bp_tab[$urandom_range(0, 3)];
                bp_hold = int'($urandom_range(10, 100));
            end else bp_hold--;
            #1;
            exp_en = (m_state == 2'd1) || (m_state == 2'd2 && !m_bp_hit());
            exp_halt = (m_state == 2'd0) || (m_state == 2'd3);
            exp_cnt = CNT_EN ? m_cnt : 32'd0;
            total++;
            if (state !== m_state || cpu_en !== exp_en || halted !== exp_halt || cycle_cnt !== exp_cnt) begin
                bad++;
                if (errs < 10)
                    $display("FAIL random cycle %0d: state=%0d cpu_en=%b halted=%b cnt=%0d want %0d %b %b %0d",
                             c, state, cpu_en, halted, cycle_cnt, m_state, exp_en, exp_halt, exp_cnt);
                errs++;
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_step_latency();
        test_bounce();
        test_reset_mid_debounce();
        test_breakpoint();
        test_break_step();
        test_wrap_and_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
